// File: rtl/lzc_norm_pipe_if.sv
// Valid/ready bus for lzc_norm_pipe: word, mode and tag in; count, normalised word, flag and tag out.
// The master side drives the input word and the result-ready signal; the slave side is the counter.
interface lzc_norm_pipe_if #(
  parameter int DATA_WDT = 48,
  parameter int USER_WDT = 4,
  parameter int CNT_WDT  = $clog2(DATA_WDT + 1)
);
  logic                in_vld;
  logic                in_rdy;
  logic [DATA_WDT-1:0] in_word;
  logic                in_mode;
  logic [USER_WDT-1:0] in_user;
  logic                out_vld;
  logic                out_rdy;
  logic [CNT_WDT-1:0]  out_cnt;
  logic [DATA_WDT-1:0] out_norm;
  logic                out_zero;
  logic [USER_WDT-1:0] out_user;

  modport master (
    output in_vld, in_word, in_mode, in_user, out_rdy,
    input  in_rdy, out_vld, out_cnt, out_norm, out_zero, out_user
  );

  modport slave (
    input  in_vld, in_word, in_mode, in_user, out_rdy,
    output in_rdy, out_vld, out_cnt, out_norm, out_zero, out_user
  );
endinterface

// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-zero / leading-sign counter with a normalising barrel shifter.
// Count and shift are one log2 normalisation; its levels are spread across the pipeline stages.
module lzc_norm_pipe #(
  parameter int DATA_WDT    = 48,
  parameter int PIPE_STAGES = 2,
  parameter int USER_WDT    = 4,
  parameter int CNT_WDT     = $clog2(DATA_WDT + 1)
) (
  input logic            clk,
  input logic            rst_n,
  lzc_norm_pipe_if.slave bus
);

  localparam int unsigned LVLS    = $clog2(DATA_WDT);
  localparam int unsigned PAD_WDT = 1 << LVLS;

  // dp drives the shift decisions (1-padded), zp is the zero-filled word that becomes out_norm.
  typedef struct packed {
    logic                mode;
    logic                zero;
    logic [USER_WDT-1:0] user;
    logic [CNT_WDT-1:0]  cnt;
    logic [PAD_WDT-1:0]  dp;
    logic [PAD_WDT-1:0]  zp;
  } stage_t;

  logic [DATA_WDT-1:0]    w_det;
  stage_t                 w_head;
  stage_t                 w_nxt [PIPE_STAGES];
  stage_t                 r_st  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] w_vin;
  logic [PIPE_STAGES-1:0] r_vld;
  logic                   w_en;
  logic                   w_unused;

  // Applies the normalisation levels owned by stage stg; the last stage also fixes the LZ all-zero count.
  function automatic stage_t norm_stage(stage_t v_in, int unsigned stg);
    stage_t      v;
    int unsigned k;
    v = v_in;
    for (int unsigned j = 0; j < LVLS; j++) begin
      k = LVLS - 1 - j;
      if ((j * PIPE_STAGES) / LVLS == stg) begin
        if ((v.dp >> (PAD_WDT - (32'd1 << k))) == '0) begin
          v.dp     = v.dp << (32'd1 << k);
          v.zp     = v.zp << (32'd1 << k);
          v.cnt[k] = 1'b1;
        end
      end
    end
    if ((stg == PIPE_STAGES - 1) && v.zero && !v.mode) begin
      v.cnt = CNT_WDT'(DATA_WDT);
    end
    return v;
  endfunction

  // LS mode becomes an LZ count over (bits below MSB) xor MSB, with a forced 1 capping it at DATA_WDT-1.
  always_comb begin
    if (bus.in_mode) begin
      w_det = {bus.in_word[DATA_WDT-2:0] ^ {(DATA_WDT-1){bus.in_word[DATA_WDT-1]}}, 1'b1};
    end else begin
      w_det = bus.in_word;
    end
  end

  always_comb begin
    w_head                            = '0;
    w_head.dp                         = '1;
    w_head.dp[PAD_WDT-1 -: DATA_WDT]  = w_det;
    w_head.zp[PAD_WDT-1 -: DATA_WDT]  = bus.in_word;
    w_head.zero = bus.in_mode ? (w_det == DATA_WDT'(1)) : (w_det == '0);
    w_head.mode = bus.in_mode;
    w_head.user = bus.in_user;
  end

  always_comb begin
    w_vin[0] = bus.in_vld;
    w_nxt[0] = norm_stage(w_head, 0);
    for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
      w_vin[s] = r_vld[s-1];
      w_nxt[s] = norm_stage(r_st[s-1], s);
    end
  end

  assign w_en = bus.out_rdy | ~r_vld[PIPE_STAGES-1];

  // Data registers load only with a valid word, so idle input never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        r_st[s] <= '0;
      end
    end else if (w_en) begin
      r_vld <= w_vin;
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        if (w_vin[s]) begin
          r_st[s] <= w_nxt[s];
        end
      end
    end
  end

  assign bus.in_rdy   = w_en;
  assign bus.out_vld  = r_vld[PIPE_STAGES-1];
  assign bus.out_cnt  = r_st[PIPE_STAGES-1].cnt;
  assign bus.out_norm = r_st[PIPE_STAGES-1].zp[PAD_WDT-1 -: DATA_WDT];
  assign bus.out_zero = r_st[PIPE_STAGES-1].zero;
  assign bus.out_user = r_st[PIPE_STAGES-1].user;

  assign w_unused = ^{r_st[PIPE_STAGES-1].dp, r_st[PIPE_STAGES-1].zp};

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed bench for lzc_norm_pipe: 8-bit/2-stage and 12-bit/3-stage instances, hand-computed results.
module tb_lzc_norm_pipe;

  typedef struct {
    logic [11:0] word;
    logic        mode;
    logic [3:0]  user;
    logic [3:0]  cnt;
    logic [11:0] norm;
    logic        zero;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  vec_t q_stim[$];
  vec_t q_exp[$];
  int   q_acc[$];

  lzc_norm_pipe_if #(.DATA_WDT(8),  .USER_WDT(4)) if8 ();
  lzc_norm_pipe_if #(.DATA_WDT(12), .USER_WDT(4)) if12 ();

  lzc_norm_pipe #(.DATA_WDT(8), .PIPE_STAGES(2), .USER_WDT(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  lzc_norm_pipe #(.DATA_WDT(12), .PIPE_STAGES(3), .USER_WDT(4)) u_dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] word, input logic mode, input logic [3:0] user,
                              input logic [3:0] cnt, input logic [11:0] norm, input logic zero);
    vec_t v;
    v.word = word; v.mode = mode; v.user = user;
    v.cnt  = cnt;  v.norm = norm; v.zero = zero;
    return v;
  endfunction

  task automatic add(input vec_t v);
    q_stim.push_back(v);
    q_exp.push_back(v);
  endtask

  task automatic drv(input int sel, input logic vld, input logic [11:0] word, input logic mode,
                     input logic [3:0] user, input logic rdy);
    if (sel == 0) begin
      if8.in_vld = vld; if8.in_word = word[7:0]; if8.in_mode = mode;
      if8.in_user = user; if8.out_rdy = rdy;
    end else begin
      if12.in_vld = vld; if12.in_word = word; if12.in_mode = mode;
      if12.in_user = user; if12.out_rdy = rdy;
    end
  endtask

  task automatic smp(input int sel, output logic irdy, output logic ovld, output logic [3:0] cnt,
                     output logic [11:0] norm, output logic zero, output logic [3:0] user);
    if (sel == 0) begin
      irdy = if8.in_rdy; ovld = if8.out_vld; cnt = if8.out_cnt;
      norm = {4'h0, if8.out_norm}; zero = if8.out_zero; user = if8.out_user;
    end else begin
      irdy = if12.in_rdy; ovld = if12.out_vld; cnt = if12.out_cnt;
      norm = if12.out_norm; zero = if12.out_zero; user = if12.out_user;
    end
  endtask

  // Streams q_stim into one DUT and checks every delivered result against q_exp, in order.
  task automatic run_stream(input int sel, input bit rnd_rdy, input int lat);
    int          cyc;
    logic        rdy, vld, irdy, ovld, zero, stall_prev;
    logic [3:0]  cnt, user, h_cnt, h_user;
    logic [11:0] norm, h_norm;
    logic        h_zero;
    vec_t        e;
    int          acc;
    cyc = 0; stall_prev = 1'b0;
    h_cnt = '0; h_user = '0; h_norm = '0; h_zero = 1'b0;
    while (q_exp.size() > 0 && cyc < 300) begin
      @(negedge clk);
      rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      vld = (q_stim.size() > 0);
      if (vld) drv(sel, 1'b1, q_stim[0].word, q_stim[0].mode, q_stim[0].user, rdy);
      else     drv(sel, 1'b0, 12'($urandom), 1'($urandom), 4'($urandom), rdy);
      #1;
      smp(sel, irdy, ovld, cnt, norm, zero, user);
      chk("in_rdy", 32'(irdy), 32'(!(ovld && !rdy)));
      if (stall_prev) begin
        chk("stall_vld",  32'(ovld), 32'd1);
        chk("stall_cnt",  32'(cnt),  32'(h_cnt));
        chk("stall_norm", 32'(norm), 32'(h_norm));
        chk("stall_zero", 32'(zero), 32'(h_zero));
        chk("stall_user", 32'(user), 32'(h_user));
      end
      if (ovld && rdy) begin
        e   = q_exp.pop_front();
        acc = q_acc.pop_front();
        chk($sformatf("cnt[u%0d]",  e.user), 32'(cnt),  32'(e.cnt));
        chk($sformatf("norm[u%0d]", e.user), 32'(norm), 32'(e.norm));
        chk($sformatf("zero[u%0d]", e.user), 32'(zero), 32'(e.zero));
        chk($sformatf("user[u%0d]", e.user), 32'(user), 32'(e.user));
        if (!rnd_rdy) chk($sformatf("lat[u%0d]", e.user), 32'(cyc - acc), 32'(lat));
      end
      if (vld && irdy) begin
        void'(q_stim.pop_front());
        q_acc.push_back(cyc);
      end
      stall_prev = ovld && !rdy;
      h_cnt = cnt; h_norm = norm; h_zero = zero; h_user = user;
      cyc++;
    end
    chk("drain_left", 32'(q_exp.size()), 32'd0);
    q_stim.delete(); q_exp.delete(); q_acc.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv(sel, 1'b0, 12'($urandom), 1'b0, 4'h0, 1'b1);
      #1;
      smp(sel, irdy, ovld, cnt, norm, zero, user);
      chk("no_extra", 32'(ovld), 32'd0);
    end
  endtask

  logic        t_irdy, t_ovld, t_zero;
  logic [3:0]  t_cnt, t_user;
  logic [11:0] t_norm;

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    drv(0, 1'b0, 12'h0, 1'b0, 4'h0, 1'b0);
    drv(1, 1'b0, 12'h0, 1'b0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    for (int sel = 0; sel < 2; sel++) begin
      smp(sel, t_irdy, t_ovld, t_cnt, t_norm, t_zero, t_user);
      chk($sformatf("rst_vld%0d",  sel), 32'(t_ovld), 32'd0);
      chk($sformatf("rst_cnt%0d",  sel), 32'(t_cnt),  32'd0);
      chk($sformatf("rst_norm%0d", sel), 32'(t_norm), 32'd0);
      chk($sformatf("rst_zero%0d", sel), 32'(t_zero), 32'd0);
      chk($sformatf("rst_user%0d", sel), 32'(t_user), 32'd0);
      chk($sformatf("rst_rdy%0d",  sel), 32'(t_irdy), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    add(mk(12'h013, 1'b0, 4'd5, 4'd3, 12'h098, 1'b0));
    run_stream(0, 1'b0, 2);

    add(mk(12'h000, 1'b0, 4'd1, 4'd8, 12'h000, 1'b1));
    add(mk(12'h080, 1'b0, 4'd2, 4'd0, 12'h080, 1'b0));
    run_stream(0, 1'b0, 2);

    add(mk(12'h0F3, 1'b1, 4'd3, 4'd3, 12'h098, 1'b0));
    add(mk(12'h00C, 1'b1, 4'd4, 4'd3, 12'h060, 1'b0));
    add(mk(12'h0FF, 1'b1, 4'd5, 4'd7, 12'h080, 1'b1));
    add(mk(12'h000, 1'b1, 4'd6, 4'd7, 12'h000, 1'b1));
    add(mk(12'h00C, 1'b0, 4'd7, 4'd4, 12'h0C0, 1'b0));
    add(mk(12'h040, 1'b1, 4'd8, 4'd0, 12'h040, 1'b0));
    add(mk(12'h0C0, 1'b1, 4'd9, 4'd1, 12'h080, 1'b0));
    add(mk(12'h001, 1'b0, 4'd10, 4'd7, 12'h080, 1'b0));
    run_stream(0, 1'b0, 2);

    add(mk(12'h001, 1'b0, 4'd1, 4'd11, 12'h800, 1'b0));
    add(mk(12'h000, 1'b0, 4'd2, 4'd12, 12'h000, 1'b1));
    add(mk(12'hFFF, 1'b1, 4'd3, 4'd11, 12'h800, 1'b1));
    add(mk(12'h07F, 1'b1, 4'd4, 4'd4,  12'h7F0, 1'b0));
    add(mk(12'h0A5, 1'b0, 4'd5, 4'd4,  12'hA50, 1'b0));
    run_stream(1, 1'b0, 3);

    add(mk(12'h001, 1'b0, 4'd1, 4'd7, 12'h080, 1'b0));
    add(mk(12'h002, 1'b0, 4'd2, 4'd6, 12'h080, 1'b0));
    add(mk(12'h030, 1'b0, 4'd3, 4'd2, 12'h0C0, 1'b0));
    add(mk(12'h0FE, 1'b1, 4'd4, 4'd6, 12'h080, 1'b0));
    add(mk(12'h03F, 1'b1, 4'd5, 4'd1, 12'h07E, 1'b0));
    add(mk(12'h0FF, 1'b0, 4'd6, 4'd0, 12'h0FF, 1'b0));
    run_stream(0, 1'b1, 2);

    // Two words in flight, then an asynchronous reset between clock edges.
    @(negedge clk); drv(0, 1'b1, 12'h011, 1'b0, 4'd11, 1'b1);
    @(negedge clk); drv(0, 1'b1, 12'h022, 1'b0, 4'd12, 1'b1);
    @(negedge clk); drv(0, 1'b0, 12'h000, 1'b0, 4'd0, 1'b1);
    #1;
    chk("pre_rst_vld", 32'(if8.out_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld",  32'(if8.out_vld),  32'd0);
    chk("async_user", 32'(if8.out_user), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("stale_vld", 32'(if8.out_vld), 32'd0);
    end
    add(mk(12'h013, 1'b0, 4'd7, 4'd3, 12'h098, 1'b0));
    run_stream(0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
Pipelined, parametrised leading-zero / leading-sign counter with built-in normalising shifter, for the fixed-point requantisation and accumulator-rescale paths. It accepts any data width, not only powers of two. It supports two count modes, selected per transaction, and a sideband tag carried alongside each word. A valid/ready handshake provides full throughput and back-pressure.

Parameters:
DATA_WDT, 48, input word width; any value >= 2.
PIPE_STAGES, 2, total latency in cycles, range 1..4; output is always registered.
USER_WDT, 4, sideband tag width, carried unchanged; must be >= 1.
CNT_WDT, $clog2(DATA_WDT+1), count width (derived; do not override).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_vld  in  1  input word valid
in_rdy  out  1  block can accept a word this cycle
in_word  in  DATA_WDT  word to analyse
in_mode  in  1  0 = count leading zeros (LZ), 1 = count redundant sign bits (LS)
in_user  in  USER_WDT  sideband tag
out_vld  out  1  result valid
out_rdy  in  1  downstream accepts result
out_cnt  out  CNT_WDT  count result
out_norm  out  DATA_WDT  in_word shifted left by out_cnt, zero-filled
out_zero  out  1  degenerate word flag
out_user  out  USER_WDT  tag of this result

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous assert, active low, synchronous deassert at the system level.
- Reset values: out_vld=0, out_cnt=0, out_norm=0, out_zero=0, out_user=0. All internal stage valid bits = 0. in_rdy=1 once reset releases.
- Transfer rules: input transfer when in_vld & in_rdy; output transfer when out_vld & out_rdy.
- Pipeline advance: en = out_rdy | ~out_vld. All stages shift only when en=1; in_rdy = en (combinational from out_rdy and out_vld; no combinational path from in_vld).
- Bubbles: interior bubbles are not compressed; stage valid bits shift with data.
- Latency: a word accepted in cycle t appears on outputs in cycle t+PIPE_STAGES, provided en was high in every intervening cycle.
- Throughput: one word per cycle while out_rdy=1.
- Stall: while out_vld=1 & out_rdy=0, every output and every stage register holds its value.
- LZ mode:
  - out_cnt = number of consecutive 0 bits from bit DATA_WDT-1 downwards; range 0..DATA_WDT.
  - out_norm = in_word << out_cnt.
  - out_zero = 1 only if in_word == 0; then out_cnt = DATA_WDT and out_norm = 0.
- LS mode:
  - out_cnt = number of consecutive bits below the MSB equal to the MSB; range 0..DATA_WDT-1.
  - out_norm = in_word << out_cnt; the sign is preserved unless the word is all-equal.
  - out_zero = 1 if in_word is all 0s or all 1s; then out_cnt = DATA_WDT-1.
  - All 1s gives out_norm = 1 followed by DATA_WDT-1 zeros; all 0s gives 0.
- Mode and tag capture: in_mode and in_user are sampled with the word and travel with it. Mixed modes back-to-back are legal.
- Non-power-of-two DATA_WDT: internally pad on the LSB side with 1s up to the next power of two. Padding must never raise the count above the limits above.
- Shifter: out_norm uses a log2 barrel shifter. The split of count and shift logic across stages is implementation choice, but latency must be exactly PIPE_STAGES.
- Reset mid-operation: all in-flight words are discarded immediately. No output is emitted for them after release.
- Unknowns: X on in_word while in_vld=0 must not propagate into out_* while out_vld=0 is held.

Test Plan:
- DATA_WDT=8, PIPE_STAGES=2, LZ mode, in_word=0x13, in_user=5 -> 2 cycles later: out_cnt=3, out_norm=0x98, out_zero=0, out_user=5.
- DATA_WDT=8, LZ mode, in_word=0x00 then 0x80 back-to-back, out_rdy=1 -> consecutive results {cnt=8, norm=0x00, zero=1} then {cnt=0, norm=0x80, zero=0}.
- DATA_WDT=8, LS mode, words 0xF3, 0x0C, 0xFF, 0x00 -> results {cnt=3, norm=0x98}, {cnt=3, norm=0x60}, {cnt=7, norm=0x80, zero=1}, {cnt=7, norm=0x00, zero=1}.
- DATA_WDT=12 (non-power-of-two), LZ mode, in_word=0x001 -> cnt=11, norm=0x800; in_word=0x000 -> cnt=12, zero=1.
- Back-pressure: stream tags 1..6 with out_rdy toggled randomly -> every tag delivered exactly once, in order, outputs stable while stalled, in_rdy low exactly when out_vld=1 & out_rdy=0.
- Assert rst_n low with 2 words in flight -> out_vld drops to 0 asynchronously; after release no stale result appears and the next accepted word has latency exactly PIPE_STAGES.
